// File: rtl/divide_unit.sv
// Multi-cycle restoring divider implementing RISC-V M DIV/DIVU/REM/REMU semantics.
// Ports: clk, reset (async high), start/kill control, A/B/Sel operands, S result, busy, done pulse.
module divide_unit #(
   parameter int size = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            kill,
   input  logic [size-1:0] A,
   input  logic [size-1:0] B,
   input  logic [1:0]      Sel,
   output logic [size-1:0] S,
   output logic            busy,
   output logic            done
);

   localparam int CW = $clog2(size + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      FIX    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [size-1:0] rem_q, rem_d;
   logic [size-1:0] quot_q, quot_d;
   logic [size-1:0] dvsr_q, dvsr_d;
   logic [1:0]      sel_q, sel_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic [size-1:0] s_q, s_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            sgn_op;
   logic            a_min, b_ones;
   logic [size:0]   shifted;
   logic [size+1:0] diff;
   logic [size-1:0] q_fix, r_fix;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      dvsr_d  = dvsr_q;
      sel_d   = sel_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      s_d     = s_q;

      sgn_op  = ~Sel[0];
      a_min   = (A == {1'b1, {(size-1){1'b0}}});
      b_ones  = (B == {size{1'b1}});

      // Partial remainder extended by the next dividend bit; a clear
      // top bit of the difference means the trial subtract succeeded.
      shifted = {rem_q, quot_q[size-1]};
      diff    = {1'b0, shifted} - {2'b00, dvsr_q};

      q_fix   = qneg_q ? -quot_q : quot_q;
      r_fix   = rneg_q ? -rem_q  : rem_q;

      if (kill) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               state_d = IDLE;
               if (start) begin
                  sel_d = Sel;
                  if (B == '0) begin
                     s_d     = Sel[1] ? A : {size{1'b1}};
                     state_d = DONE;
                  end else if (sgn_op && a_min && b_ones) begin
                     s_d     = Sel[1] ? '0 : A;
                     state_d = DONE;
                  end else begin
                     rem_d   = '0;
                     quot_d  = (sgn_op && A[size-1]) ? -A : A;
                     dvsr_d  = (sgn_op && B[size-1]) ? -B : B;
                     qneg_d  = sgn_op && (A[size-1] ^ B[size-1]);
                     rneg_d  = sgn_op && A[size-1];
                     cnt_d   = CW'(size);
                     state_d = DIVIDE;
                  end
               end
            end
            DIVIDE: begin
               if (!diff[size+1]) begin
                  rem_d  = diff[size-1:0];
                  quot_d = {quot_q[size-2:0], 1'b1};
               end else begin
                  rem_d  = shifted[size-1:0];
                  quot_d = {quot_q[size-2:0], 1'b0};
               end
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = FIX;
               end
            end
            FIX: begin
               s_d     = sel_q[1] ? r_fix : q_fix;
               state_d = DONE;
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d == DIVIDE) || (state_d == FIX);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         dvsr_q  <= '0;
         sel_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         s_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         dvsr_q  <= dvsr_d;
         sel_q   <= sel_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         s_q     <= s_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign S    = s_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_divide_unit.sv
// Directed self-checking bench for divide_unit (size=32).
// Latency is counted as the cycle index of done relative to the start cycle.
module tb_divide_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic        kill;
   logic [31:0] A;
   logic [31:0] B;
   logic [1:0]  Sel;
   logic [31:0] S;
   logic        busy;
   logic        done;

   int checks;
   int failures;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   divide_unit #(.size(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .kill  (kill),
      .A     (A),
      .B     (B),
      .Sel   (Sel),
      .S     (S),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents one operation for a single edge; returns 1ns after that edge.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] sel);
      A     = a;
      B     = b;
      Sel   = sel;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Waits (bounded) for done; n0 is the cycle index already reached.
   task automatic wait_done(input int n0, output int lat, output int bc);
      lat = n0;
      bc  = busy ? 1 : 0;
      while (!done && lat < 80) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) bc++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      kill  = 1'b0;
      A     = '0;
      B     = '0;
      Sel   = '0;
      #12;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || S !== 32'h0) begin
         failures++;
         $display("FAIL reset_state busy=%b done=%b S=%h want 0 0 0", busy, done, S);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_signed;
      int lat, bc;
      start_op(32'hFFFFFFF9, 32'd2, OP_DIV);
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'hFFFFFFFD || lat != 34) begin
         failures++;
         $display("FAIL div_m7_2 S=%h lat=%0d want FFFFFFFD 34", S, lat);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse done=%b want 0", done);
      end
      start_op(32'hFFFFFFF9, 32'd2, OP_REM);
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'hFFFFFFFF || lat != 34) begin
         failures++;
         $display("FAIL rem_m7_2 S=%h lat=%0d want FFFFFFFF 34", S, lat);
      end
      start_op(32'd7, 32'hFFFFFFFE, OP_DIV);
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'hFFFFFFFD) begin
         failures++;
         $display("FAIL div_7_m2 S=%h want FFFFFFFD", S);
      end
      start_op(32'd7, 32'hFFFFFFFE, OP_REM);
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'h00000001) begin
         failures++;
         $display("FAIL rem_7_m2 S=%h want 00000001", S);
      end
      start_op(32'hFFFFFFF8, 32'hFFFFFFFE, OP_DIV);
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'h00000004) begin
         failures++;
         $display("FAIL div_m8_m2 S=%h want 00000004", S);
      end
   endtask

   task automatic test_unsigned;
      int lat, bc;
      start_op(32'hFFFFFFFF, 32'h10, OP_DIVU);
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'h0FFFFFFF || lat != 34 || bc != 33) begin
         failures++;
         $display("FAIL divu_ff_10 S=%h lat=%0d busy=%0d want 0FFFFFFF 34 33", S, lat, bc);
      end
      start_op(32'hFFFFFFFF, 32'h10, OP_REMU);
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'h0000000F || bc != 33) begin
         failures++;
         $display("FAIL remu_ff_10 S=%h busy=%0d want 0000000F 33", S, bc);
      end
      start_op(32'hFFFFFFFF, 32'hFFFFFFFF, OP_DIVU);
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'h00000001 || lat != 34) begin
         failures++;
         $display("FAIL divu_ones S=%h lat=%0d want 00000001 34", S, lat);
      end
   endtask

   task automatic test_special;
      int lat, bc;
      start_op(32'd5, 32'd0, OP_DIV);
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'hFFFFFFFF || lat != 1) begin
         failures++;
         $display("FAIL div_by0 S=%h lat=%0d want FFFFFFFF 1", S, lat);
      end
      start_op(32'd5, 32'd0, OP_REM);
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'h00000005 || lat != 1) begin
         failures++;
         $display("FAIL rem_by0 S=%h lat=%0d want 00000005 1", S, lat);
      end
      start_op(32'h80000000, 32'hFFFFFFFF, OP_DIV);
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'h80000000 || lat != 1) begin
         failures++;
         $display("FAIL div_ovf S=%h lat=%0d want 80000000 1", S, lat);
      end
      start_op(32'h80000000, 32'hFFFFFFFF, OP_REM);
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'h00000000 || lat != 1) begin
         failures++;
         $display("FAIL rem_ovf S=%h lat=%0d want 00000000 1", S, lat);
      end
   endtask

   task automatic test_ignore_kill;
      int lat, bc;
      int seen;
      start_op(32'd100, 32'd7, OP_DIVU);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      A     = 32'd50;
      B     = 32'd5;
      Sel   = OP_DIV;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(11, lat, bc);
      checks++;
      if (S !== 32'd14 || lat != 34) begin
         failures++;
         $display("FAIL busy_start_ignored S=%0d lat=%0d want 14 34", S, lat);
      end
      start_op(32'd1000, 32'd3, OP_DIV);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || S !== 32'd14) begin
         failures++;
         $display("FAIL kill_state busy=%b done=%b S=%0d want 0 0 14", busy, done, S);
      end
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done || busy || S !== 32'd14) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL kill_quiet bad_cycles=%0d want 0", seen);
      end
      A     = 32'd9;
      B     = 32'd3;
      Sel   = OP_DIVU;
      start = 1'b1;
      kill  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      kill  = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL kill_over_start busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_reset_mid;
      int lat, bc;
      start_op(32'd100, 32'd7, OP_DIVU);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || S !== 32'h0) begin
         failures++;
         $display("FAIL reset_mid busy=%b done=%b S=%h want 0 0 0", busy, done, S);
      end
      @(negedge clk);
      reset = 1'b0;
      start_op(32'd100, 32'd7, OP_DIVU);
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'd14 || lat != 34) begin
         failures++;
         $display("FAIL after_reset S=%0d lat=%0d want 14 34", S, lat);
      end
   endtask

   task automatic test_back_to_back;
      int lat, bc;
      start_op(32'd20, 32'd6, OP_REMU);
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'd2 || lat != 34) begin
         failures++;
         $display("FAIL b2b_first S=%0d lat=%0d want 2 34", S, lat);
      end
      start_op(32'hFFFFFFFF, 32'h10, OP_DIVU);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || S !== 32'd2) begin
         failures++;
         $display("FAIL b2b_accept busy=%b done=%b S=%0d want 1 0 2", busy, done, S);
      end
      wait_done(1, lat, bc);
      checks++;
      if (S !== 32'h0FFFFFFF || lat != 34) begin
         failures++;
         $display("FAIL b2b_second S=%h lat=%0d want 0FFFFFFF 34", S, lat);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_signed();
      test_unsigned();
      test_special();
      test_ignore_kill();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
